// File: rtl/bitop_pkg.sv
// Shared constants for the bitwise round-robin scheduler family.
package bitop_pkg;
  localparam logic OP_AND = 1'b1;
  localparam logic OP_OR  = 1'b0;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin arbiter: the search begins one slot after last_grant and wraps.
module rr_arbiter_comb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_gnt
);

  int idx;

  // Wrap by subtraction so that non-power-of-2 NREQ never selects a stale index.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_gnt    = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_gnt && req[idx]) begin
        any_gnt         = 1'b1;
        gnt_idx         = IDW'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitop_rr_sched.sv
// Round-robin sharing of a single AND/OR unit among NREQ requesters, with one output register slot.
module bitop_rr_sched
  import bitop_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_op
);

  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [NREQ-1:0]            gnt_onehot;
  logic [IDW-1:0]             gnt_idx;
  logic [IDW-1:0]             last_grant;
  logic                       any_gnt;
  logic                       can_issue;
  logic [WIDTH-1:0]           a_w, b_w;
  logic                       op_w;

  assign a_arr = req_a;
  assign b_arr = req_b;

  rr_arbiter_comb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_gnt    (any_gnt)
  );

  // The slot may be refilled in the same cycle it is popped, giving full throughput.
  assign can_issue = !rsp_valid || rsp_ready;
  assign req_ready = (can_issue && !rst) ? gnt_onehot : '0;

  assign a_w  = a_arr[gnt_idx];
  assign b_w  = b_arr[gnt_idx];
  assign op_w = req_op[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_op     <= 1'b0;
      last_grant <= IDW'(NREQ-1);
    end else if (can_issue) begin
      if (any_gnt) begin
        rsp_valid  <= 1'b1;
        rsp_data   <= (op_w == OP_AND) ? (a_w & b_w) : (a_w | b_w);
        rsp_id     <= gnt_idx;
        rsp_op     <= op_w;
        last_grant <= gnt_idx;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitop_rr_sched.sv
// Directed bench for bitop_rr_sched (NREQ=4, WIDTH=8) with hand-computed expectations.
module tb_bitop_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_op;

  int nvec = 0;
  int nerr = 0;

  // Hand-computed results for the round-robin operand set below
  logic [7:0] exp_data [4] = '{8'h88, 8'h3F, 8'h30, 8'h52};
  logic       exp_op   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  bitop_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_op    (rsp_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] id, input logic op);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, ".data"},  32'(rsp_data),  32'(d));
    chk({tag, ".id"},    32'(rsp_id),    32'(id));
    chk({tag, ".op"},    32'(rsp_op),    32'(op));
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'hF; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    tick(); tick();
    chk_rsp("reset", 1'b0, 8'h00, 2'd0, 1'b0);

    // Single AND request
    rst = 1'b0; req_valid = 4'b0001; req_op = 4'b0001;
    req_a = {8'h00, 8'h00, 8'h00, 8'hF0}; req_b = {8'h00, 8'h00, 8'h00, 8'h3C};
    rsp_ready = 1'b1;
    #1 chk("and_ready", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("and", 1'b1, 8'h30, 2'd0, 1'b1);

    // Single OR request from requester 2
    req_valid = 4'b0100; req_op = 4'b0000;
    req_a = {8'h00, 8'hF0, 8'h00, 8'h00}; req_b = {8'h00, 8'h3C, 8'h00, 8'h00};
    #1 chk("or_ready", 32'(req_ready), 32'h4);
    tick();
    chk_rsp("or", 1'b1, 8'hFC, 2'd2, 1'b0);

    // Drain: valid drops, payload holds
    req_valid = 4'b0000;
    tick();
    chk_rsp("drain", 1'b0, 8'hFC, 2'd2, 1'b0);

    // Reset so that rotation starts at requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'hF; req_op = 4'b0101;
    req_a = {8'h12, 8'hF0, 8'h0F, 8'hCC}; req_b = {8'h40, 8'h3C, 8'h30, 8'hAA};
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      chk_rsp($sformatf("rr%0d", k), 1'b1, exp_data[k % 4], 2'(k % 4), exp_op[k % 4]);
    end

    // Backpressure: slot holds id 3, pointer stays at 3
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
      tick();
      chk_rsp($sformatf("bp%0d", k), 1'b1, 8'h52, 2'd3, 1'b0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("bp_release", 1'b1, 8'h88, 2'd0, 1'b1);

    // Move pointer to 1, then skip idle requesters 2 and 0->3 first
    req_valid = 4'b0010;
    tick();
    chk_rsp("skip_setup", 1'b1, 8'h3F, 2'd1, 1'b0);
    req_valid = 4'b1001;
    #1 chk("skip_ready3", 32'(req_ready), 32'h8);
    tick();
    chk_rsp("skip3", 1'b1, 8'h52, 2'd3, 1'b0);
    #1 chk("skip_ready0", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("skip0", 1'b1, 8'h88, 2'd0, 1'b1);

    // Reset while a result is stalled
    rsp_ready = 1'b0; req_valid = 4'hF;
    tick();
    chk("mid_pending", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0; rsp_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("post_rst", 1'b1, 8'h88, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
